// File: rtl/debug_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_port_arbiter                                           |
// | Description : Shares the CPU debug port between two requesters (0 = JTAG   |
// |               bridge, 1 = serial monitor). Grants exclusive ownership,     |
// |               sequences procedure runs and reports completion to owner.    |
// | Config      : DEBUG_ARB_TIMEOUT_EN adds a per-wait-state abort counter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debug_port_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_seize,
  input  logic [1:0]            req_run,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [31:0]           req_wr_val,
  input  logic [1:0]            req_wr_en,
  output logic [1:0]            req_grant,
  output logic [1:0]            req_stopped,
  output logic [1:0]            req_done,
  output logic [1:0]            req_err,
  output logic [15:0]           req_val,
  output logic                  debug_seize,
  output logic                  debug_run,
  output logic [ADDR_W-1:0]     debug_addr,
  output logic [15:0]           debug_wr_val,
  output logic                  debug_wr_en,
  input  logic                  debug_stopped,
  input  logic [15:0]           debug_val
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OWNED  = 3'd1,
    ST_RUN_LO = 3'd2,
    ST_RUN_HI = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [1:0]          grant_q, grant_d;
  logic                run_pend_q, run_pend_d;
  logic                debug_run_q, debug_run_d;
  logic [ADDR_W-1:0]   debug_addr_q, debug_addr_d;
  logic                debug_wr_en_q, debug_wr_en_d;
  logic [15:0]         debug_wr_val_q, debug_wr_val_d;
  logic [15:0]         req_val_q, req_val_d;
  logic [1:0]          req_done_q, req_done_d;
  logic [1:0]          req_err_q, req_err_d;

  // Owner's view of the request inputs; the non-owner is never looked at
  logic                own_seize;
  logic                own_run;
  logic                own_wr_en;
  logic [ADDR_W-1:0]   own_addr;
  logic [15:0]         own_wr_val;
  logic [1:0]          owner_onehot;
  logic                timeout_hit;

  assign own_seize    = owner_q ? req_seize[1] : req_seize[0];
  assign own_run      = owner_q ? req_run[1]   : req_run[0];
  assign own_wr_en    = owner_q ? req_wr_en[1] : req_wr_en[0];
  assign own_addr     = owner_q ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign own_wr_val   = owner_q ? req_wr_val[31:16] : req_wr_val[15:0];
  assign owner_onehot = owner_q ? 2'b10 : 2'b01;

`ifdef DEBUG_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] timer_q, timer_d;

  assign timeout_hit = (timer_q == TIMEOUT_LAST);

  // Wait-state watchdog: restarts on every state change, counts while waiting on the CPU
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = 16'd0;
    end else if (state_q == ST_RUN_LO || state_q == ST_RUN_HI) begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer_q <= 16'd0;
    else          timer_q <= timer_d;
  end
`else
  // Without the watchdog a wait state never aborts
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign timeout_hit        = 1'b0;
`endif

  // Arbitration, run sequencing and write forwarding
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    grant_d        = grant_q;
    run_pend_d     = run_pend_q;
    debug_run_d    = 1'b0;
    debug_addr_d   = debug_addr_q;
    debug_wr_en_d  = 1'b0;
    debug_wr_val_d = debug_wr_val_q;
    req_val_d      = req_val_q;
    req_done_d     = 2'b00;
    req_err_d      = 2'b00;

    // Write strobes pass through whenever no procedure is executing
    if ((state_q == ST_OWNED || state_q == ST_DONE) && own_wr_en) begin
      debug_wr_en_d  = 1'b1;
      debug_wr_val_d = own_wr_val;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_seize != 2'b00) begin
          // On a tie the requester that did not own last time wins
          owner_d      = (req_seize == 2'b11) ? ~last_owner_q : req_seize[1];
          last_owner_d = owner_d;
          grant_d      = owner_d ? 2'b10 : 2'b01;
          state_d      = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (run_pend_q) begin
          // Run that arrived together with a write goes out one cycle late
          run_pend_d  = 1'b0;
          debug_run_d = 1'b1;
          state_d     = ST_RUN_LO;
        end else if (!own_seize) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end else if (own_run) begin
          debug_addr_d = own_addr;
          if (own_wr_en) begin
            run_pend_d = 1'b1;
          end else begin
            debug_run_d = 1'b1;
            state_d     = ST_RUN_LO;
          end
        end
      end
      ST_RUN_LO: begin
        if (!debug_stopped) begin
          state_d = ST_RUN_HI;
        end else if (timeout_hit) begin
          state_d    = ST_DONE;
          req_done_d = owner_onehot;
          req_err_d  = owner_onehot;
        end
      end
      ST_RUN_HI: begin
        if (debug_stopped) begin
          state_d    = ST_DONE;
          req_done_d = owner_onehot;
          req_val_d  = debug_val;
        end else if (timeout_hit) begin
          state_d    = ST_DONE;
          req_done_d = owner_onehot;
          req_err_d  = owner_onehot;
        end
      end
      ST_DONE: begin
        // A release requested mid-run takes effect here
        if (!own_seize) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OWNED;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      owner_q        <= 1'b0;
      last_owner_q   <= 1'b1;
      grant_q        <= 2'b00;
      run_pend_q     <= 1'b0;
      debug_run_q    <= 1'b0;
      debug_addr_q   <= '0;
      debug_wr_en_q  <= 1'b0;
      debug_wr_val_q <= 16'd0;
      req_val_q      <= 16'd0;
      req_done_q     <= 2'b00;
      req_err_q      <= 2'b00;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      grant_q        <= grant_d;
      run_pend_q     <= run_pend_d;
      debug_run_q    <= debug_run_d;
      debug_addr_q   <= debug_addr_d;
      debug_wr_en_q  <= debug_wr_en_d;
      debug_wr_val_q <= debug_wr_val_d;
      req_val_q      <= req_val_d;
      req_done_q     <= req_done_d;
      req_err_q      <= req_err_d;
    end
  end

  assign req_grant    = grant_q;
  assign req_stopped  = grant_q & {2{debug_stopped}};
  assign req_done     = req_done_q;
  assign req_err      = req_err_q;
  assign req_val      = req_val_q;
  assign debug_seize  = |grant_q;
  assign debug_run    = debug_run_q;
  assign debug_addr   = debug_addr_q;
  assign debug_wr_val = debug_wr_val_q;
  assign debug_wr_en  = debug_wr_en_q;

endmodule
`default_nettype wire
